// File: rtl/instr_enc_pkg.sv
// -----------------------------------------------------------------------------
// instr_enc_pkg
// Shared definitions for the instruction encoder:
//   - instruction class enumeration (request-channel class codes 0..12)
//   - major opcode and R-type funct constants
//   - encoder FSM state enumeration
//   - NOP word used for branch-delay padding
//   - is_branch() helper for the classes that may need a trailing pad
// -----------------------------------------------------------------------------
package instr_enc_pkg;

  typedef enum logic [3:0] {
    CLS_ADD  = 4'd0,
    CLS_SUB  = 4'd1,
    CLS_AND  = 4'd2,
    CLS_OR   = 4'd3,
    CLS_SLT  = 4'd4,
    CLS_ADDI = 4'd5,
    CLS_SLTI = 4'd6,
    CLS_BEQ  = 4'd7,
    CLS_BNE  = 4'd8,
    CLS_BGE  = 4'd9,
    CLS_BGT  = 4'd10,
    CLS_LW   = 4'd11,
    CLS_SW   = 4'd12
  } instr_class_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_WRITE,
    ST_PAD,
    ST_DONE
  } enc_state_e;

  // Major opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGE   = 6'b000001;
  localparam logic [5:0] OP_BGT   = 6'b000111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  function automatic logic is_branch(input logic [3:0] cls);
    return (cls == CLS_BEQ) || (cls == CLS_BNE) || (cls == CLS_BGE) || (cls == CLS_BGT);
  endfunction

endpackage

// File: rtl/instr_field_encoder.sv
// -----------------------------------------------------------------------------
// instr_field_encoder
// Purely combinational mapping of an instruction class plus register and
// immediate fields to a 32-bit machine word.
//   cls     in  4   instruction class (13..15 are illegal)
//   rs      in  5   source register
//   rt      in  5   second source / target register
//   rd      in  5   destination register (R-type only)
//   imm     in  16  immediate, passed through unmodified (branch offset in words)
//   word    out 32  encoded instruction, zero for an illegal class
//   illegal out 1   class has no encoding
// -----------------------------------------------------------------------------
module instr_field_encoder
  import instr_enc_pkg::*;
(
  input  logic [3:0]  cls,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic       is_rtype;
  logic [5:0] opcode;
  logic [5:0] funct;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case can leave it holding state (an inferred latch).
  always_comb begin
    is_rtype = 1'b0;
    opcode   = OP_RTYPE;
    funct    = 6'b000000;
    illegal  = 1'b0;
    case (cls)
      CLS_ADD:  begin is_rtype = 1'b1; funct = FUNCT_ADD; end
      CLS_SUB:  begin is_rtype = 1'b1; funct = FUNCT_SUB; end
      CLS_AND:  begin is_rtype = 1'b1; funct = FUNCT_AND; end
      CLS_OR:   begin is_rtype = 1'b1; funct = FUNCT_OR;  end
      CLS_SLT:  begin is_rtype = 1'b1; funct = FUNCT_SLT; end
      CLS_ADDI: opcode = OP_ADDI;
      CLS_SLTI: opcode = OP_SLTI;
      CLS_BEQ:  opcode = OP_BEQ;
      CLS_BNE:  opcode = OP_BNE;
      CLS_BGE:  opcode = OP_BGE;
      CLS_BGT:  opcode = OP_BGT;
      CLS_LW:   opcode = OP_LW;
      CLS_SW:   opcode = OP_SW;
      default:  illegal = 1'b1;
    endcase

    if (illegal) begin
      word = 32'h0000_0000;
    end else if (is_rtype) begin
      word = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
    end else begin
      word = {opcode, rs, rt, imm};
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Accepts instruction requests during a session, encodes them and writes the
// words to consecutive instruction-memory addresses starting at base_addr_i.
//
// Build option: define INSTR_ENC_NOP_PAD_EN to follow every written branch
// with a NOP pad word at the next address (the pad counts toward capacity).
//
// Parameter: MAX_INSTR  capacity in words (default 256, maximum 1023)
//
// Ports:
//   clk_i, rst_i                clock, asynchronous active-high reset
//   start_i, base_addr_i        open a session at a first byte address
//   busy_o, done_o              session active / session finished
//   req_valid_i/req_ready_o     request handshake
//   req_class_i, req_rs_i, req_rt_i, req_rd_i, req_imm_i, req_last_i
//                               request fields, last marks end of session
//   im_we_o, im_addr_o, im_data_o, im_ack_i
//                               instruction-memory write, held until ack
//   count_o                     words written this session
//   err_o                       sticky: illegal class or capacity overflow
// -----------------------------------------------------------------------------
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int MAX_INSTR = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] base_addr_i,
  output logic        busy_o,
  output logic        done_o,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  req_class_i,
  input  logic [4:0]  req_rs_i,
  input  logic [4:0]  req_rt_i,
  input  logic [4:0]  req_rd_i,
  input  logic [15:0] req_imm_i,
  input  logic        req_last_i,
  output logic        im_we_o,
  output logic [31:0] im_addr_o,
  output logic [31:0] im_data_o,
  input  logic        im_ack_i,
  output logic [9:0]  count_o,
  output logic        err_o
);

  localparam logic [9:0] CAPACITY = 10'(MAX_INSTR);

  enc_state_e  state, state_nxt;
  logic [31:0] addr_q, data_q;
  logic [9:0]  count_q;
  logic        err_q, last_q, pad_q;

  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        pad_req;
  logic        full;

  // Datapath controls decoded by the FSM
  logic        load_session, capture, word_done, set_err;

  instr_field_encoder u_field_encoder (
    .cls     (req_class_i),
    .rs      (req_rs_i),
    .rt      (req_rt_i),
    .rd      (req_rd_i),
    .imm     (req_imm_i),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

`ifdef INSTR_ENC_NOP_PAD_EN
  assign pad_req = is_branch(req_class_i);
`else
  assign pad_req = 1'b0;
`endif

  assign full      = (count_q == CAPACITY);
  assign im_addr_o = addr_q;
  assign count_o   = count_q;
  assign err_o     = err_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    req_ready_o  = 1'b0;
    im_we_o      = 1'b0;
    im_data_o    = data_q;
    load_session = 1'b0;
    capture      = 1'b0;
    word_done    = 1'b0;
    set_err      = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        done_o = (state == ST_DONE);
        if (start_i) begin
          load_session = 1'b1;
          state_nxt    = ST_ACCEPT;
        end
      end

      ST_ACCEPT: begin
        busy_o      = 1'b1;
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          // Illegal or over-capacity requests are consumed without a write.
          if (enc_illegal || full) begin
            set_err   = 1'b1;
            state_nxt = req_last_i ? ST_DONE : ST_ACCEPT;
          end else begin
            capture   = 1'b1;
            state_nxt = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        busy_o  = 1'b1;
        im_we_o = 1'b1;
        if (im_ack_i) begin
          word_done = 1'b1;
          if (pad_q) begin
            state_nxt = ST_PAD;
          end else begin
            state_nxt = last_q ? ST_DONE : ST_ACCEPT;
          end
        end
      end

      ST_PAD: begin
        busy_o    = 1'b1;
        im_data_o = NOP_WORD;
        // Capacity is rechecked here because the branch itself may have
        // taken the last free slot.
        if (full) begin
          set_err   = 1'b1;
          state_nxt = last_q ? ST_DONE : ST_ACCEPT;
        end else begin
          im_we_o = 1'b1;
          if (im_ack_i) begin
            word_done = 1'b1;
            state_nxt = last_q ? ST_DONE : ST_ACCEPT;
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: every register, including the data word, is cleared on reset so
  // all outputs read zero while rst_i is held.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= 32'h0000_0000;
      data_q  <= 32'h0000_0000;
      count_q <= 10'd0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      pad_q   <= 1'b0;
    end else begin
      if (load_session) begin
        addr_q  <= base_addr_i;
        count_q <= 10'd0;
        err_q   <= 1'b0;
      end
      if (capture) begin
        data_q <= enc_word;
        last_q <= req_last_i;
        pad_q  <= pad_req;
      end
      if (word_done) begin
        addr_q  <= addr_q + 32'd4;
        count_q <= count_q + 10'd1;
      end
      if (set_err) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule
